clic_irq_tx: RTL and testbench

Interrupt-selection transmitter for the Sclic-enabled CVA6 build (256 CLIC sources). It sits between the per-source pending/level/SHV state and the core's CLIC interrupt port.
- It sweeps the sources in fixed-width groups and selects the highest-level pending source above the current threshold.
- It presents that source to the core with a valid/ready handshake.
- It withdraws a stale request through the kill-request/kill-ack handshake.

---
 rtl/clic_irq_tx.sv | 197 +++++++++++++++++++
 tb/tb_clic_irq_tx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_irq_tx.sv
// clic_irq_tx: CLIC interrupt selection and presentation to the core.
// Optional macro CLIC_TX_ACK_CLEAR_EN adds a post-accept clear pulse.
module clic_irq_tx #(
    parameter int NumSrc     = 256,
    parameter int ScanWidth  = 16,
    parameter int LevelWidth = 8,
    parameter int IdWidth    = $clog2(NumSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumSrc-1:0]            pending_i,
    input  logic [NumSrc*LevelWidth-1:0] level_i,
    input  logic [NumSrc-1:0]            shv_i,
    input  logic [LevelWidth-1:0]        mth_i,
    output logic                         irq_valid_o,
    input  logic                         irq_ready_i,
    output logic [IdWidth-1:0]           irq_id_o,
    output logic [LevelWidth-1:0]        irq_level_o,
    output logic                         irq_shv_o,
    output logic                         irq_kill_req_o,
    input  logic                         irq_kill_ack_i,
    output logic                         irq_clr_o,
    output logic [IdWidth-1:0]           irq_clr_id_o
);

    localparam int G  = NumSrc / ScanWidth;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] LastGrp = GW'(G - 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESENT,
        KILL
    } state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         grp_q, grp_d;
    logic                  best_vld_q, best_vld_d;
    logic [IdWidth-1:0]    best_id_q, best_id_d;
    logic [LevelWidth-1:0] best_lvl_q, best_lvl_d;
    logic                  best_shv_q, best_shv_d;
    logic                  valid_q, valid_d;
    logic                  kill_q, kill_d;
    logic [IdWidth-1:0]    id_q, id_d;
    logic [LevelWidth-1:0] lvl_q, lvl_d;
    logic                  shv_q, shv_d;

    logic                  c_vld;
    logic [IdWidth-1:0]    c_id;
    logic [LevelWidth-1:0] c_lvl;
    logic                  c_shv;
    logic [IdWidth-1:0]    src;
    logic [LevelWidth-1:0] src_lvl;
    logic                  kill_cond;

    // Fold the current group into the running best; ascending id keeps ties on the lower id.
    always_comb begin
        c_vld   = best_vld_q;
        c_id    = best_id_q;
        c_lvl   = best_lvl_q;
        c_shv   = best_shv_q;
        src     = '0;
        src_lvl = '0;
        for (int i = 0; i < ScanWidth; i++) begin
            src     = IdWidth'(int'(grp_q) * ScanWidth + i);
            src_lvl = level_i[int'(src)*LevelWidth +: LevelWidth];
            if (pending_i[src] && (!c_vld || (src_lvl > c_lvl))) begin
                c_vld = 1'b1;
                c_id  = src;
                c_lvl = src_lvl;
                c_shv = shv_i[src];
            end
        end
    end

    assign kill_cond = !pending_i[id_q] || (mth_i >= lvl_q);

    // Next-state and registered-output logic for the scan/present/kill FSM.
    always_comb begin
        state_d    = state_q;
        grp_d      = grp_q;
        best_vld_d = best_vld_q;
        best_id_d  = best_id_q;
        best_lvl_d = best_lvl_q;
        best_shv_d = best_shv_q;
        valid_d    = valid_q;
        kill_d     = kill_q;
        id_d       = id_q;
        lvl_d      = lvl_q;
        shv_d      = shv_q;
        unique case (state_q)
            SCAN: begin
                best_vld_d = c_vld;
                best_id_d  = c_id;
                best_lvl_d = c_lvl;
                best_shv_d = c_shv;
                grp_d      = grp_q + GW'(1);
                if (grp_q == LastGrp) begin
                    grp_d      = '0;
                    best_vld_d = 1'b0;
                    best_id_d  = '0;
                    best_lvl_d = '0;
                    best_shv_d = 1'b0;
                    if (c_vld && (c_lvl > mth_i)) begin
                        state_d = PRESENT;
                        valid_d = 1'b1;
                        id_d    = c_id;
                        lvl_d   = c_lvl;
                        shv_d   = c_shv;
                    end
                end
            end
            PRESENT: begin
                if (irq_ready_i) begin
                    state_d = SCAN;
                    valid_d = 1'b0;
                end else if (kill_cond) begin
                    state_d = KILL;
                    valid_d = 1'b0;
                    kill_d  = 1'b1;
                end
            end
            KILL: begin
                if (irq_kill_ack_i) begin
                    state_d = SCAN;
                    kill_d  = 1'b0;
                end
            end
            default: begin
                state_d = SCAN;
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State, sweep and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SCAN;
            grp_q      <= '0;
            best_vld_q <= 1'b0;
            best_id_q  <= '0;
            best_lvl_q <= '0;
            best_shv_q <= 1'b0;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            id_q       <= '0;
            lvl_q      <= '0;
            shv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            best_vld_q <= best_vld_d;
            best_id_q  <= best_id_d;
            best_lvl_q <= best_lvl_d;
            best_shv_q <= best_shv_d;
            valid_q    <= valid_d;
            kill_q     <= kill_d;
            id_q       <= id_d;
            lvl_q      <= lvl_d;
            shv_q      <= shv_d;
        end
    end

    assign irq_valid_o    = valid_q;
    assign irq_kill_req_o = kill_q;
    assign irq_id_o       = id_q;
    assign irq_level_o    = lvl_q;
    assign irq_shv_o      = shv_q;

`ifdef CLIC_TX_ACK_CLEAR_EN
    logic               clr_q;
    logic [IdWidth-1:0] clr_id_q;
    logic               accept;

    assign accept = valid_q && irq_ready_i;

    // One-cycle clear pulse carrying the id just accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_q    <= 1'b0;
            clr_id_q <= '0;
        end else begin
            clr_q    <= accept;
            clr_id_q <= accept ? id_q : '0;
        end
    end

    assign irq_clr_o    = clr_q;
    assign irq_clr_id_o = clr_id_q;
`else
    assign irq_clr_o    = 1'b0;
    assign irq_clr_id_o = '0;
`endif

endmodule

// File: tb/tb_clic_irq_tx.sv
// tb_clic_irq_tx: vector table, random trials against an argmax model,
// and directed handshake sequences for clic_irq_tx.
module tb_clic_irq_tx;

    localparam int NS = 256;
    localparam int LW = 8;
    localparam int IW = 8;
    localparam int G  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     pend;
    logic [NS*LW-1:0]  lvl;
    logic [NS-1:0]     shv;
    logic [LW-1:0]     mth;
    logic              ready;
    logic              ack;
    logic              valid;
    logic [IW-1:0]     id;
    logic [LW-1:0]     olvl;
    logic              oshv;
    logic              kreq;
    logic              clr;
    logic [IW-1:0]     clr_id;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clic_irq_tx dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pending_i      (pend),
        .level_i        (lvl),
        .shv_i          (shv),
        .mth_i          (mth),
        .irq_valid_o    (valid),
        .irq_ready_i    (ready),
        .irq_id_o       (id),
        .irq_level_o    (olvl),
        .irq_shv_o      (oshv),
        .irq_kill_req_o (kreq),
        .irq_kill_ack_i (ack),
        .irq_clr_o      (clr),
        .irq_clr_id_o   (clr_id)
    );

    typedef struct {
        int a;
        int la;
        int b;
        int lb;
        int mth;
        bit ev;
        int eid;
        int elv;
        bit eshv;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_clr(input string name, input bit exp_pulse, input int exp_id);
`ifdef CLIC_TX_ACK_CLEAR_EN
        chk({name, " clr"}, int'(clr), int'(exp_pulse));
        chk({name, " clr_id"}, int'(clr_id), exp_pulse ? exp_id : 0);
`else
        chk({name, " clr"}, int'(clr), 0);
        chk({name, " clr_id"}, int'(clr_id), 0);
`endif
    endtask

    task automatic clear_inputs();
        pend  = '0;
        lvl   = '0;
        shv   = '0;
        mth   = '0;
        ready = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic set_src(input int k, input int l, input bit s);
        pend[k]          = 1'b1;
        lvl[k*LW +: LW]  = LW'(l);
        shv[k]           = s;
    endtask

    task automatic chk_zero(input string name);
        chk({name, " valid"}, int'(valid), 0);
        chk({name, " kill"}, int'(kreq), 0);
        chk({name, " id"}, int'(id), 0);
        chk({name, " lvl"}, int'(olvl), 0);
        chk({name, " shv"}, int'(oshv), 0);
        chk({name, " clr"}, int'(clr), 0);
        chk({name, " clr_id"}, int'(clr_id), 0);
    endtask

    // Apply inputs with a reset edge so the sweep starts at group 0 on stable inputs.
    task automatic run_vec(input string name, input bit ev, input int eid,
                           input int elv, input bit eshv);
        bit early;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero({name, " reset"});
        early = 1'b0;
        for (int k = 1; k < G; k++) begin
            step();
            if (valid) early = 1'b1;
        end
        chk({name, " early valid"}, int'(early), 0);
        step();
        chk({name, " valid"}, int'(valid), int'(ev));
        if (ev) begin
            chk({name, " id"}, int'(id), eid);
            chk({name, " lvl"}, int'(olvl), elv);
            chk({name, " shv"}, int'(oshv), int'(eshv));
            ready = 1'b1;
            step();
            ready = 1'b0;
            chk({name, " accept"}, int'(valid), 0);
            chk_clr({name, " ack"}, 1'b1, eid);
            step();
            chk_clr({name, " post"}, 1'b0, 0);
        end else begin
            early = 1'b0;
            for (int k = 0; k < 2 * G + 2; k++) begin
                step();
                if (valid) early = 1'b1;
            end
            chk({name, " never valid"}, int'(early), 0);
        end
    endtask

    function automatic void model(input logic [NS-1:0] p, input logic [NS*LW-1:0] l,
                                  input logic [NS-1:0] s, input logic [LW-1:0] m,
                                  output bit v, output int bid, output int blv,
                                  output bit bsh);
        int best;
        best = -1;
        bid  = 0;
        for (int k = 0; k < NS; k++) begin
            if (p[k] && int'(l[k*LW +: LW]) > best) begin
                best = int'(l[k*LW +: LW]);
                bid  = k;
            end
        end
        v   = (best >= 0) && (best > int'(m));
        blv = v ? best : 0;
        bsh = v ? s[bid] : 1'b0;
        if (!v) bid = 0;
    endfunction

    vec_t vt[9];

    initial begin
        bit  ev;
        int  eid;
        int  elv;
        bit  esh;
        bit  seen;
        int  cnt;

        vt[0] = '{37, 'h40, 37, 'h40, 0, 1, 37, 'h40, 1};
        vt[1] = '{200, 'h80, 5, 'h90, 0, 1, 5, 'h90, 0};
        vt[2] = '{9, 'h90, 5, 'h90, 0, 1, 5, 'h90, 0};
        vt[3] = '{12, 'h30, 12, 'h30, 'h30, 0, 0, 0, 0};
        vt[4] = '{12, 'h30, 12, 'h30, 'h2F, 1, 12, 'h30, 1};
        vt[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[6] = '{255, 'hFF, 254, 'hFF, 'hFE, 1, 254, 'hFF, 0};
        vt[7] = '{16, 1, 15, 1, 0, 1, 15, 1, 0};
        vt[8] = '{100, 'h10, 101, 'h11, 'h10, 1, 101, 'h11, 0};

        rst = 1'b1;
        clear_inputs();
        step();
        step();

        foreach (vt[i]) begin
            clear_inputs();
            set_src(vt[i].b, vt[i].lb, 1'b0);
            set_src(vt[i].a, vt[i].la, 1'b1);
            mth = LW'(vt[i].mth);
            run_vec($sformatf("vec%0d", i), vt[i].ev, vt[i].eid, vt[i].elv, vt[i].eshv);
        end

        for (int t = 0; t < 60; t++) begin
            clear_inputs();
            cnt = $urandom_range(0, 6);
            for (int j = 0; j < cnt; j++)
                set_src($urandom_range(0, NS - 1), $urandom_range(0, 255), 1'($urandom));
            mth = LW'($urandom_range(0, 255));
            if (t % 4 == 0) mth = '0;
            model(pend, lvl, shv, mth, ev, eid, elv, esh);
            run_vec($sformatf("rnd%0d", t), ev, eid, elv, esh);
        end

        // Tie at 0x90 between 5 and 9; after accepting 5 and clearing it, 9 follows.
        clear_inputs();
        set_src(200, 'h80, 0);
        set_src(5, 'h90, 0);
        set_src(9, 'h90, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (G) step();
        chk("tie valid", int'(valid), 1);
        chk("tie id", int'(id), 5);
        ready   = 1'b1;
        pend[5] = 1'b0;
        step();
        chk("tie accept", int'(valid), 0);
        chk_clr("tie clr", 1'b1, 5);
        repeat (G - 1) step();
        chk("next early", int'(valid), 0);
        step();
        chk("next valid", int'(valid), 1);
        chk("next id", int'(id), 9);
        chk("next shv", int'(oshv), 1);
        step();
        ready = 1'b0;

        // Threshold lowered mid-run; presentation within one sweep.
        clear_inputs();
        set_src(12, 'h30, 0);
        mth = 'h30;
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (valid) seen = 1'b1;
        end
        chk("thr blocked", int'(seen), 0);
        mth  = 'h2F;
        seen = 1'b0;
        for (int k = 0; k < G + 2 && !seen; k++) begin
            step();
            if (valid) seen = 1'b1;
        end
        chk("thr lowered", int'(seen), 1);
        chk("thr id", int'(id), 12);

        // Withdrawal: drop pending of presented id 3 with ready low.
        clear_inputs();
        set_src(3, 'h50, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (G) step();
        chk("wd valid", int'(valid), 1);
        pend[3] = 1'b0;
        step();
        chk("wd valid low", int'(valid), 0);
        chk("wd kill", int'(kreq), 1);
        ready = 1'b1;
        repeat (3) step();
        ready = 1'b0;
        chk("wd kill held", int'(kreq), 1);
        chk_clr("wd no clr", 1'b0, 0);
        ack     = 1'b1;
        pend[3] = 1'b1;
        step();
        ack = 1'b0;
        chk("wd kill drop", int'(kreq), 0);
        chk("wd idle", int'(valid), 0);
        repeat (G - 1) step();
        chk("wd resweep early", int'(valid), 0);
        step();
        chk("wd resweep", int'(valid), 1);
        chk("wd resweep id", int'(id), 3);

        // Stability: no preemption while held with ready low.
        set_src(100, 'hF0, 0);
        ack  = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            step();
            if (!valid || id != 8'd3 || olvl != 8'h50 || !oshv || kreq) seen = 1'b1;
        end
        ack = 1'b0;
        chk("stable", int'(seen), 0);

        // Ready and kill in the same cycle: accept wins.
        pend[3] = 1'b0;
        ready   = 1'b1;
        step();
        ready = 1'b0;
        chk("race valid", int'(valid), 0);
        chk("race kill", int'(kreq), 0);
        chk_clr("race clr", 1'b1, 3);

        // Reset in KILL aborts without a handshake.
        clear_inputs();
        set_src(3, 'h50, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (G) step();
        pend[3] = 1'b0;
        step();
        chk("rk kill", int'(kreq), 1);
        rst     = 1'b1;
        pend[3] = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("rk reset");
        repeat (G - 1) step();
        chk("rk early", int'(valid), 0);
        step();
        chk("rk valid", int'(valid), 1);
        chk("rk id", int'(id), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
